noc_mmr_if: RTL and testbench

- Parametrised memory-mapped NoC interface block. It replaces the flat MMR byte array that LOADNOC/STORENOC access through R31.
- Provides NUM_CH independent channels. Each channel has a TX FIFO and an RX FIFO, a STATUS register and a CTRL register, mapped at BASE_ADDR.
- Sits on the pipeline's MEM stage (CPU side) and on NoC router ports (valid/ready side).
- Adds three things the flat MMR lacks: real flow control, loopback mode, and sticky error flags.

---
 rtl/noc_mmr_if.sv | 156 +++++++++++++++
 tb/tb_noc_mmr_if.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mmr_if.sv
// noc_mmr_if: memory-mapped NoC channels with TX/RX FIFOs, flow control, loopback and sticky error flags
module noc_mmr_if #(
  parameter int          DATA_W     = 32,
  parameter int          NUM_CH     = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [31:0]              addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rd_valid,
  output logic [NUM_CH-1:0]        tx_valid,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  input  logic [NUM_CH-1:0]        tx_ready,
  input  logic [NUM_CH-1:0]        rx_valid,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic [NUM_CH-1:0]        rx_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]       off;
  logic              in_range;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] sel;
  logic [DATA_W-1:0] rd_word [NUM_CH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q;

  assign off      = addr - BASE_ADDR;
  assign in_range = (addr >= BASE_ADDR) && (off < 32'(NUM_CH * 16));
  assign reg_sel  = off[3:2];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic              en_q, en_d, lb_q, lb_d, of_q, of_d, uf_q, uf_d;
    logic [PW-1:0]     tx_cnt, rx_cnt;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_push_req, rx_pop_req, w1c, ctrl_wr, flush;
    logic              noc_tx_pop, noc_rx_push, lb_xfer;
    logic              tx_pop, tx_push, rx_push, rx_pop, of_set, uf_set;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [31:0]       status;

    assign sel[c]      = in_range && (off[6:4] == 3'(c));
    assign tx_push_req = wr_en && sel[c] && (reg_sel == 2'd0);
    assign rx_pop_req  = rd_en && sel[c] && (reg_sel == 2'd1);
    assign w1c         = wr_en && sel[c] && (reg_sel == 2'd2);
    assign ctrl_wr     = wr_en && sel[c] && (reg_sel == 2'd3);
    assign flush       = ctrl_wr && wdata[2];

    assign tx_cnt   = tx_wp_q - tx_rp_q;
    assign rx_cnt   = rx_wp_q - rx_rp_q;
    assign tx_full  = tx_cnt == PW'(FIFO_DEPTH);
    assign tx_empty = tx_cnt == '0;
    assign rx_full  = rx_cnt == PW'(FIFO_DEPTH);
    assign rx_empty = rx_cnt == '0;
    assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];
    assign rx_head  = rx_mem[rx_rp_q[AW-1:0]];

    // rx_ready is held low while reset is asserted even though CTRL resets to enabled
    assign tx_valid[c]                  = en_q && !lb_q && !tx_empty;
    assign rx_ready[c]                  = reset && en_q && !lb_q && !rx_full;
    assign tx_data[c*DATA_W +: DATA_W]  = tx_head;

    assign noc_tx_pop  = tx_valid[c] && tx_ready[c];
    assign noc_rx_push = rx_valid[c] && rx_ready[c];
    assign lb_xfer     = en_q && lb_q && !tx_empty && !rx_full;
    assign tx_pop      = noc_tx_pop || lb_xfer;
    assign rx_push     = noc_rx_push || lb_xfer;
    // a pop on the same edge frees a slot, so a push into a full TX FIFO still lands
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign of_set      = tx_push_req && tx_full && !tx_pop;
    assign rx_pop      = rx_pop_req && !rx_empty;
    assign uf_set      = rx_pop_req && rx_empty;

    assign status = {8'd0, 8'(tx_cnt), 8'(rx_cnt), 2'b00, uf_q, of_q,
                     rx_empty, rx_full, tx_empty, tx_full};

    assign rd_word[c] = !sel[c]            ? '0 :
                        reg_sel == 2'd1    ? (rx_empty ? '0 : rx_head) :
                        reg_sel == 2'd2    ? DATA_W'(status) :
                        reg_sel == 2'd3    ? DATA_W'({lb_q, en_q}) : '0;

    // next-state: flush empties both FIFOs and clears sticky flags, beating any transfer
    always_comb begin
      tx_wp_d = flush ? '0 : tx_wp_q + PW'(tx_push);
      tx_rp_d = flush ? '0 : tx_rp_q + PW'(tx_pop);
      rx_wp_d = flush ? '0 : rx_wp_q + PW'(rx_push);
      rx_rp_d = flush ? '0 : rx_rp_q + PW'(rx_pop);
      en_d    = ctrl_wr ? wdata[0] : en_q;
      lb_d    = ctrl_wr ? wdata[1] : lb_q;
      of_d    = flush ? 1'b0 : of_set ? 1'b1 : (w1c && wdata[4]) ? 1'b0 : of_q;
      uf_d    = flush ? 1'b0 : uf_set ? 1'b1 : (w1c && wdata[5]) ? 1'b0 : uf_q;
    end

    // channel pointer, control and sticky-flag registers
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        tx_wp_q <= '0;
        tx_rp_q <= '0;
        rx_wp_q <= '0;
        rx_rp_q <= '0;
        en_q    <= 1'b1;
        lb_q    <= 1'b0;
        of_q    <= 1'b0;
        uf_q    <= 1'b0;
      end else begin
        tx_wp_q <= tx_wp_d;
        tx_rp_q <= tx_rp_d;
        rx_wp_q <= rx_wp_d;
        rx_rp_q <= rx_rp_d;
        en_q    <= en_d;
        lb_q    <= lb_d;
        of_q    <= of_d;
        uf_q    <= uf_d;
      end
    end

    // FIFO storage; contents are meaningless outside the pointer window so no reset
    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= wdata;
      if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= lb_xfer ? tx_head : rx_data[c*DATA_W +: DATA_W];
    end
  end

  // read mux: at most one channel is selected, so OR-ing the per-channel words is exact
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      for (int c = 0; c < NUM_CH; c++) rdata_d = rdata_d | rd_word[c];
    end
  end

  // registered read port: one-cycle latency, data held until the next read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_noc_mmr_if.sv
// tb_noc_mmr_if: directed and randomized checks of noc_mmr_if against a queue-based reference model
module tb_noc_mmr_if;
  localparam int DW    = 32;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;

  logic              clk = 0, reset = 1, wr_en = 0, rd_en = 0;
  logic [31:0]       addr = 0, wdata = 0, rdata;
  logic              rd_valid;
  logic [NCH-1:0]    tx_valid, rx_ready, tx_ready = 0, rx_valid = 0;
  logic [NCH*DW-1:0] tx_data, rx_data = '0;

  int n_chk = 0, n_pass = 0;

  logic [31:0] txq [NCH][$];
  logic [31:0] rxq [NCH][$];
  logic        m_en [NCH], m_lb [NCH], m_of [NCH], m_uf [NCH];
  logic [31:0] e_rdata;
  logic        e_rdv;

  always #5 clk = ~clk;

  noc_mmr_if #(.DATA_W(DW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .BASE_ADDR(32'h4000)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rd_valid(rd_valid), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready)
  );

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      txq[c].delete();
      rxq[c].delete();
      m_en[c] = 1;
      m_lb[c] = 0;
      m_of[c] = 0;
      m_uf[c] = 0;
    end
    e_rdata = 0;
    e_rdv   = 0;
  endtask

  function automatic logic [31:0] m_status(int c);
    return {8'd0, 8'(txq[c].size()), 8'(rxq[c].size()), 2'b00, m_uf[c], m_of[c],
            rxq[c].size() == 0, rxq[c].size() == DEPTH, txq[c].size() == 0, txq[c].size() == DEPTH};
  endfunction

  function automatic int m_ch(logic [31:0] a);
    return (a >= 32'h4000 && a < 32'h4000 + NCH * 16) ? int'((a - 32'h4000) >> 4) : -1;
  endfunction

  // one clock edge of the abstract channel model, applied to the current inputs
  task automatic model_update();
    int ch, r;
    bit txv, rxr, lbx, tpop, full0, of_set, uf_set, here;
    logic [31:0] h, nv;
    ch = m_ch(addr);
    r  = int'(((addr - 32'h4000) >> 2) & 3);
    if (rd_en) begin
      nv = 0;
      if (ch >= 0) begin
        if (r == 1 && rxq[ch].size() > 0) nv = rxq[ch][0];
        if (r == 2) nv = m_status(ch);
        if (r == 3) nv = {30'd0, m_lb[ch], m_en[ch]};
      end
      e_rdata = nv;
    end
    e_rdv = rd_en;
    for (int c = 0; c < NCH; c++) begin
      here   = (ch == c);
      txv    = m_en[c] && !m_lb[c] && txq[c].size() > 0;
      rxr    = m_en[c] && !m_lb[c] && rxq[c].size() < DEPTH;
      lbx    = m_en[c] && m_lb[c] && txq[c].size() > 0 && rxq[c].size() < DEPTH;
      tpop   = (txv && tx_ready[c]) || lbx;
      full0  = txq[c].size() == DEPTH;
      of_set = 0;
      uf_set = 0;
      if (rd_en && here && r == 1) begin
        if (rxq[c].size() > 0) void'(rxq[c].pop_front());
        else uf_set = 1;
      end
      if (tpop) begin
        h = txq[c].pop_front();
        if (lbx) rxq[c].push_back(h);
      end
      if (rxr && rx_valid[c]) rxq[c].push_back(rx_data[c*DW +: DW]);
      if (wr_en && here && r == 0) begin
        if (!full0 || tpop) txq[c].push_back(wdata);
        else of_set = 1;
      end
      if (of_set) m_of[c] = 1;
      else if (wr_en && here && r == 2 && wdata[4]) m_of[c] = 0;
      if (uf_set) m_uf[c] = 1;
      else if (wr_en && here && r == 2 && wdata[5]) m_uf[c] = 0;
      if (wr_en && here && r == 3) begin
        m_en[c] = wdata[0];
        m_lb[c] = wdata[1];
        if (wdata[2]) begin
          txq[c].delete();
          rxq[c].delete();
          m_of[c] = 0;
          m_uf[c] = 0;
        end
      end
    end
  endtask

  // called at posedge+1 after inputs are driven; checks outputs, advances model, waits one cycle
  task automatic step();
    logic ev;
    #1;
    for (int c = 0; c < NCH; c++) begin
      ev = m_en[c] && !m_lb[c] && txq[c].size() > 0;
      chk($sformatf("tx_valid[%0d]", c), tx_valid[c], ev);
      if (ev) chk($sformatf("tx_data[%0d]", c), tx_data[c*DW +: DW], txq[c][0]);
      chk($sformatf("rx_ready[%0d]", c), rx_ready[c], m_en[c] && !m_lb[c] && rxq[c].size() < DEPTH);
    end
    chk("rd_valid", rd_valid, e_rdv);
    chk("rdata", rdata, e_rdata);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    wr_en = 1; addr = a; wdata = d;
    step();
    wr_en = 0;
  endtask

  task automatic rd(logic [31:0] a);
    rd_en = 1; addr = a;
    step();
    rd_en = 0;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0; tx_ready = 0; rx_valid = 0;
  endtask

  task automatic async_reset();
    #2 reset = 0;
    #1;
    chk("rst tx_valid", tx_valid, 0);
    chk("rst rx_ready", rx_ready, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rdata", rdata, 0);
    model_reset();
    #2 reset = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #3 reset = 0;
    @(posedge clk);
    #1;
    chk("reset rd_valid", rd_valid, 0);
    chk("reset rdata", rdata, 0);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset rx_ready", rx_ready, 0);
    @(posedge clk);
    #1 reset = 1;
    step();
    rd(32'h4008);
    chk("reset status0", rdata, 32'h0000000A);
    rd(32'h400C);
    chk("reset ctrl0", rdata, 32'h1);

    tx_ready = 4'b0001;
    wr(32'h4000, 32'hA1);
    wr(32'h4000, 32'hA2);
    wr(32'h4000, 32'hA3);
    step();
    rd(32'h4008);
    chk("tx drained status", rdata, 32'h0000000A);

    tx_ready = 0;
    for (int i = 0; i < 5; i++) wr(32'h4010, 32'hB0 + i);
    rd(32'h4018);
    chk("overflow status", rdata, 32'h00040019);
    wr(32'h4018, 32'h10);
    rd(32'h4018);
    chk("overflow cleared", rdata, 32'h00040009);

    rx_valid = 4'b0100;
    rx_data[2*DW +: DW] = 32'h55;
    step();
    rx_valid = 0;
    rd(32'h4024);
    chk("rx pop", rdata, 32'h55);
    rd(32'h4024);
    chk("rx empty read", rdata, 32'h0);
    rd(32'h4028);
    chk("underflow status", rdata, 32'h0000002A);

    wr(32'h403C, 32'h3);
    wr(32'h4030, 32'h11);
    wr(32'h4030, 32'h22);
    step();
    rd(32'h4034);
    chk("loopback 1st", rdata, 32'h11);
    rd(32'h4034);
    chk("loopback 2nd", rdata, 32'h22);

    wr(32'h4000, 32'hC1);
    wr(32'h4000, 32'hC2);
    wr(32'h400C, 32'h5);
    rd(32'h4008);
    chk("flush status", rdata, 32'h0000000A);
    rd(32'h400C);
    chk("flush ctrl", rdata, 32'h1);

    wr(32'h4000, 32'hD1);
    wr(32'h4000, 32'hD2);
    wr(32'h4000, 32'hD3);
    step();
    chk("pre-reset tx_valid0", tx_valid[0], 1);
    async_reset();
    rd(32'h4008);
    chk("post-reset status0", rdata, 32'h0000000A);

    for (int i = 0; i < 3000; i++) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, NCH - 1);
      wr_en = $urandom_range(0, 2) == 0;
      rd_en = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 15) == 0)
        addr = $urandom_range(0, 1) ? 32'h4040 + ($urandom & 32'hFF) : 32'h3FF0 + ($urandom & 32'hF);
      else
        addr = 32'h4000 + c * 16 + r * 4 + $urandom_range(0, 3);
      wdata = $urandom;
      if (r == 3) wdata = {29'd0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0};
      tx_ready = (i < 1500) ? 4'($urandom & $urandom & $urandom) : 4'($urandom);
      rx_valid = (i < 1500) ? 4'($urandom) : 4'($urandom & $urandom & $urandom);
      rx_data  = {$urandom, $urandom, $urandom, $urandom};
      if (i == 2000) begin
        idle();
        async_reset();
      end
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
